// File: rtl/div_unit_32_pkg.sv
// rtl/div_unit_32_pkg.sv - shared types and constants for the restoring divider
package div_pkg;

   localparam int WIDTH       = 32;
   localparam int DIV_LATENCY = WIDTH + 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // Absolute value of an operand; raw value when operating unsigned.
   // The most negative value wraps to itself, which is the correct
   // unsigned magnitude 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                            input logic             sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/div_unit_32_if.sv
// rtl/div_unit_32_if.sv - operand/result bundle between control unit and divider
interface div_unit_32_if #(parameter int W = div_pkg::WIDTH);

   logic           Start;
   logic           Signed;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic [2*W-1:0] Z;
   logic           Busy;
   logic           Done;
   logic           DivZero;

   modport master (
      output Start, Signed, A, B,
      input  Z, Busy, Done, DivZero
   );

   modport slave (
      input  Start, Signed, A, B,
      output Z, Busy, Done, DivZero
   );

endinterface

// File: rtl/div_unit_32_step.sv
// rtl/div_unit_32_step.sv - one combinational restoring-division iteration
module div_step #(
   parameter int WIDTH = div_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   // Shift the next dividend bit into the remainder and trial-subtract;
   // the extra top bit of diff is the borrow that decides restore or keep.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      diff     = {1'b0, shifted} - {2'b00, divisor};
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH+1]) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_unit_32.sv
// rtl/div_unit_32.sv - multi-cycle signed/unsigned divider feeding the Z register
module div_unit_32
   import div_pkg::*;
(
   input  logic         Clock,
   input  logic         Clear,
   div_unit_32_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   div_state_t       state;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH-1:0] a_raw;
   logic             neg_q;
   logic             neg_r;
   logic             dz;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (dvsr),
      .rem_next (rem_nx),
      .quo_next (quo_nx)
   );

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state       <= IDLE;
         rem         <= '0;
         quo         <= '0;
         dvsr        <= '0;
         a_raw       <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dz          <= 1'b0;
         count       <= '0;
         bus.Z       <= '0;
         bus.Busy    <= 1'b0;
         bus.Done    <= 1'b0;
         bus.DivZero <= 1'b0;
      end else begin
         bus.Done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.Start) begin
                  a_raw       <= bus.A;
                  dvsr        <= mag(bus.B, bus.Signed);
                  quo         <= mag(bus.A, bus.Signed);
                  rem         <= '0;
                  count       <= '0;
                  neg_q       <= bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                  neg_r       <= bus.Signed & bus.A[WIDTH-1];
                  dz          <= (bus.B == '0);
                  bus.DivZero <= 1'b0;
                  bus.Busy    <= 1'b1;
                  state       <= (bus.B == '0) ? FIX : RUN;
               end else begin
                  bus.Busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            RUN: begin
               rem   <= rem_nx;
               quo   <= quo_nx;
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (dz) begin
                  bus.Z       <= {a_raw, {WIDTH{1'b1}}};
                  bus.DivZero <= 1'b1;
               end else begin
                  bus.Z <= {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
               end
               bus.Busy <= 1'b0;
               bus.Done <= 1'b1;
               state    <= DONE;
            end
            default: begin
               bus.Busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
